// File: rtl/cpu_stack_pkg.sv
// Shared definitions for the operand-stack unit: default sizes, entry tag
// field location and the stack-capacity helper.
package cpu_stack_pkg;

  localparam int DEF_DATA_W = 35;
  localparam int DEF_SP_W   = 11;

  // An entry is a 32-bit value with a 3-bit tag in the top bits.
  localparam int TAG_LSB = 32;
  localparam int TAG_MSB = 34;

  function automatic int unsigned max_sp(input int unsigned sp_w);
    return (32'd1 << sp_w) - 32'd1;
  endfunction

endpackage

// File: rtl/cpu_stack_ram.sv
// Simple-dual-port stack storage: one synchronous write port and one
// synchronous write-first read port; the array itself is never reset.
module cpu_stack_ram
  import cpu_stack_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_SP_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];

  // Array write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read with same-cycle write forwarded so readers never see stale data.
  always_ff @(posedge clk) begin
    if (re) begin
      if (we && (waddr == raddr)) begin
        rdata <= wdata;
      end else begin
        rdata <= mem_r[raddr];
      end
    end
  end

endmodule

// File: rtl/cpu_stack_unit.sv
// Operand-stack unit: stack pointer, cached top-of-stack with one-cycle
// refill, writeback commits, kill-time restores and a top-n read port.
module cpu_stack_unit
  import cpu_stack_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SP_W   = DEF_SP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit_valid,
  input  logic [SP_W-1:0]   commit_pop,
  input  logic              commit_push,
  input  logic [DATA_W-1:0] commit_data,
  input  logic              restore_valid,
  input  logic [SP_W-1:0]   restore_sp,
  input  logic              rdn_valid,
  input  logic [SP_W-1:0]   rdn_off,
  output logic [SP_W-1:0]   sp,
  output logic [DATA_W-1:0] top0,
  output logic [DATA_W-1:0] topn,
  output logic              topn_valid,
  output logic              topn_err,
  output logic              err_overflow,
  output logic              err_underflow
);

  localparam logic [SP_W:0] MAX_SP = (SP_W+1)'(max_sp(SP_W));

  logic [SP_W-1:0]   sp_r;
  logic [DATA_W-1:0] top0_r;
  logic              refill_r;
  logic              topn_ok_r;
  logic              topn_valid_r;
  logic              topn_err_r;
  logic              err_ov_r;
  logic              err_un_r;

  logic              underflow_s;
  logic              overflow_s;
  logic              push_eff_s;
  logic [SP_W:0]     pop_s;
  logic [SP_W:0]     base_s;
  logic [SP_W:0]     total_s;
  logic [SP_W:0]     sp_next_s;
  logic              we_s;
  logic [SP_W-1:0]   waddr_s;
  logic              refill_s;
  logic [SP_W-1:0]   raddr_a_s;
  logic              rdn_err_s;
  logic [SP_W-1:0]   raddr_b_s;
  logic [DATA_W-1:0] rdata_a_s;
  logic [DATA_W-1:0] rdata_b_s;

  // Commit arithmetic, write and refill address selection.
  always_comb begin
    pop_s       = {1'b0, commit_pop};
    underflow_s = pop_s > {1'b0, sp_r};
    if (underflow_s) begin
      base_s = {(SP_W+1){1'b0}};
    end else begin
      base_s = {1'b0, sp_r} - pop_s;
    end
    total_s    = base_s + {{SP_W{1'b0}}, commit_push};
    overflow_s = total_s > MAX_SP;
    push_eff_s = commit_push && !overflow_s;
    if (overflow_s) begin
      sp_next_s = base_s;
    end else begin
      sp_next_s = total_s;
    end
    we_s    = commit_valid && push_eff_s;
    waddr_s = sp_next_s[SP_W-1:0] - SP_W'(1);
    // A restore owns the refill port even when a commit lands in the same cycle.
    if (restore_valid) begin
      refill_s  = restore_sp != {SP_W{1'b0}};
      raddr_a_s = restore_sp - SP_W'(1);
    end else begin
      refill_s  = commit_valid && !push_eff_s && (sp_next_s != {(SP_W+1){1'b0}});
      raddr_a_s = sp_next_s[SP_W-1:0] - SP_W'(1);
    end
    rdn_err_s = rdn_off >= sp_r;
    raddr_b_s = sp_r - SP_W'(1) - rdn_off;
  end

  // Stack pointer, cached top, top-n status and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_r         <= {SP_W{1'b0}};
      top0_r       <= {DATA_W{1'b0}};
      refill_r     <= 1'b0;
      topn_ok_r    <= 1'b0;
      topn_valid_r <= 1'b0;
      topn_err_r   <= 1'b0;
      err_ov_r     <= 1'b0;
      err_un_r     <= 1'b0;
    end else begin
      if (refill_r) begin
        top0_r   <= rdata_a_s;
        refill_r <= 1'b0;
      end
      if (restore_valid) begin
        sp_r     <= restore_sp;
        refill_r <= refill_s;
        if (!refill_s) begin
          top0_r <= {DATA_W{1'b0}};
        end
      end else if (commit_valid) begin
        sp_r <= sp_next_s[SP_W-1:0];
        if (push_eff_s) begin
          top0_r   <= commit_data;
          refill_r <= 1'b0;
        end else if (sp_next_s == {(SP_W+1){1'b0}}) begin
          top0_r   <= {DATA_W{1'b0}};
          refill_r <= 1'b0;
        end else begin
          refill_r <= 1'b1;
        end
      end
      if (commit_valid && underflow_s) begin
        err_un_r <= 1'b1;
      end
      if (commit_valid && overflow_s) begin
        err_ov_r <= 1'b1;
      end
      topn_valid_r <= rdn_valid;
      topn_err_r   <= rdn_valid && rdn_err_s;
      topn_ok_r    <= rdn_valid && !rdn_err_s;
    end
  end

  cpu_stack_ram #(.DATA_W(DATA_W), .ADDR_W(SP_W)) u_ram_a (
    .clk   (clk),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (commit_data),
    .re    (refill_s),
    .raddr (raddr_a_s),
    .rdata (rdata_a_s)
  );

  cpu_stack_ram #(.DATA_W(DATA_W), .ADDR_W(SP_W)) u_ram_b (
    .clk   (clk),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (commit_data),
    .re    (rdn_valid),
    .raddr (raddr_b_s),
    .rdata (rdata_b_s)
  );

  assign sp            = sp_r;
  assign top0          = refill_r ? rdata_a_s : top0_r;
  assign topn          = topn_ok_r ? rdata_b_s : {DATA_W{1'b0}};
  assign topn_valid    = topn_valid_r;
  assign topn_err      = topn_err_r;
  assign err_overflow  = err_ov_r;
  assign err_underflow = err_un_r;

endmodule
